// File: rtl/stream_alpha_if.sv
// Trellis tables and the symbol stream bundle for the forward (alpha) recursion engine.
interface trellis_if #(
  parameter int STATES          = 4,
  parameter int BITS_PER_SYMBOL = 2
);
  localparam int SW = (STATES > 1) ? $clog2(STATES) : 1;

  logic [STATES-1:0][1:0][SW-1:0]              NEXT_STATE;
  logic [STATES-1:0][1:0][BITS_PER_SYMBOL-1:0] OUTPUT;

  modport provider (output NEXT_STATE, output OUTPUT);
  modport consumer (input  NEXT_STATE, input  OUTPUT);
endinterface

interface stream_alpha_if #(
  parameter int BITS           = 16,
  parameter int STATES         = 4,
  parameter int OUTPUT_SYMBOLS = 4,
  parameter int INDEX_BITS     = 4
);
  logic                                  in_valid;
  logic                                  block_start;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]   branch_metric;
  logic                                  out_valid;
  logic [STATES-1:0][BITS-1:0]           AlphaMetric;
  logic [INDEX_BITS-1:0]                 symbol_index;
  logic                                  block_last;
  logic                                  final_valid;
  logic [STATES-1:0][BITS-1:0]           FinalAlpha;
  logic                                  protocol_error;

  modport master (
    output in_valid, block_start, branch_metric,
    input  out_valid, AlphaMetric, symbol_index, block_last,
           final_valid, FinalAlpha, protocol_error
  );
  modport slave (
    input  in_valid, block_start, branch_metric,
    output out_valid, AlphaMetric, symbol_index, block_last,
           final_valid, FinalAlpha, protocol_error
  );
endinterface

// File: rtl/stream_alpha.sv
// Forward alpha recursion: one binary16 add-compare-select step per accepted symbol,
// emitting the alpha vector that applies before each symbol plus the terminal vector.
module stream_alpha #(
  parameter int    BITS            = 16,
  parameter string PRECISION       = "HALF",
  parameter int    STATES          = 4,
  parameter int    BITS_PER_SYMBOL = 2,
  parameter int    SYMBOLS         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  trellis_if.consumer   trellis,
  stream_alpha_if.slave bus
);
  localparam int OUTPUT_SYMBOLS = 2**BITS_PER_SYMBOL;
  localparam int SW = (STATES > 1) ? $clog2(STATES) : 1;
  localparam int IW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [BITS-1:0] MINUS_INF = (PRECISION == "HALF") ? BITS'(16'hFBFF) : '1;
  localparam logic [STATES-1:0][BITS-1:0] INIT_VEC = {{(STATES-1){MINUS_INF}}, {BITS{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  // binary16 add, round-to-nearest-even, with -inf pulled back to the most negative finite value
  function automatic logic [15:0] hadd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] a, b, res;
    logic [4:0]  ea, eb, d;
    logic [10:0] ma, mb;
    logic [13:0] al, bl, bl0, mask;
    logic [14:0] sum;
    logic [5:0]  e;
    logic [11:0] mr;
    logic        sgn;
    if (x[14:0] < y[14:0]) begin a = y; b = x; end
    else begin a = x; b = y; end
    ea  = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb  = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma  = {a[14:10] != 5'd0, a[9:0]};
    mb  = {b[14:10] != 5'd0, b[9:0]};
    d   = ea - eb;
    al  = {ma, 3'b000};
    bl0 = {mb, 3'b000};
    mask = '0;
    if (d >= 5'd14) begin
      bl = {13'd0, |mb};
    end else begin
      mask = (14'd1 << d) - 14'd1;
      bl   = (bl0 >> d) | {13'd0, |(bl0 & mask)};
    end
    sum = (a[15] ^ b[15]) ? ({1'b0, al} - {1'b0, bl}) : ({1'b0, al} + {1'b0, bl});
    e   = {1'b0, ea};
    if (sum[14]) begin
      sum = {1'b0, sum[14:2], sum[1] | sum[0]};
      e   = e + 6'd1;
    end else begin
      for (int unsigned i = 0; i < 13; i++) begin
        if (!sum[13] && e > 6'd1) begin
          sum = {sum[13:0], 1'b0};
          e   = e - 6'd1;
        end
      end
    end
    mr = {1'b0, sum[13:3]} + {11'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
    if (mr[11]) begin
      mr = {1'b0, mr[11:1]};
      e  = e + 6'd1;
    end
    sgn = (mr == 12'd0) ? (a[15] & b[15]) : a[15];
    if (e >= 6'd31) res = {sgn, 5'h1F, 10'd0};
    else            res = {sgn, mr[10] ? e[4:0] : 5'd0, mr[9:0]};
    if (res == 16'hFC00) res = 16'hFBFF;
    return res;
  endfunction

  // Numeric greater-than; +0 and -0 compare equal
  function automatic logic hgt(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] kx, ky;
    kx = x[15] ? ~x : {1'b1, x[14:0]};
    ky = y[15] ? ~y : {1'b1, y[14:0]};
    return (kx > ky) && !(x[14:0] == 15'd0 && y[14:0] == 15'd0);
  endfunction

  state_t                              state_q, state_d;
  logic [IW-1:0]                       counter_q, cur_idx;
  logic [STATES-1:0][BITS-1:0]         alpha_q, src, rec;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0] gamma;
  logic [BITS-1:0]                     cand;
  logic                                found, accept, drop, is_last;

  always_comb begin
    gamma   = bus.branch_metric;
    accept  = bus.in_valid && (bus.block_start || state_q == RUN);
    drop    = bus.in_valid && !bus.block_start && state_q == IDLE;
    cur_idx = bus.block_start ? '0 : counter_q;
    is_last = (cur_idx == IW'(SYMBOLS - 1));
    src     = bus.block_start ? INIT_VEC : alpha_q;
    rec     = '0;
    cand    = '0;
    found   = 1'b0;
    // First predecessor seeds the max so a lone path is kept even if it saturates
    for (int unsigned t = 0; t < STATES; t++) begin
      rec[t] = MINUS_INF;
      found  = 1'b0;
      for (int unsigned s = 0; s < STATES; s++) begin
        for (int unsigned u = 0; u < 2; u++) begin
          if (trellis.NEXT_STATE[s][u] == SW'(t)) begin
            cand = hadd(src[s], gamma[trellis.OUTPUT[s][u]]);
            if (!found || hgt(cand, rec[t])) rec[t] = cand;
            found = 1'b1;
          end
        end
      end
    end
    state_d = state_q;
    if (accept) state_d = is_last ? IDLE : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q          <= '0;
      alpha_q            <= INIT_VEC;
      bus.out_valid      <= 1'b0;
      bus.AlphaMetric    <= '0;
      bus.symbol_index   <= '0;
      bus.block_last     <= 1'b0;
      bus.final_valid    <= 1'b0;
      bus.FinalAlpha     <= '0;
      bus.protocol_error <= 1'b0;
    end else begin
      bus.protocol_error <= drop;
      bus.final_valid    <= bus.block_last;
      if (accept) begin
        bus.out_valid    <= 1'b1;
        bus.AlphaMetric  <= src;
        bus.symbol_index <= cur_idx;
        bus.block_last   <= is_last;
        alpha_q          <= rec;
        counter_q        <= is_last ? '0 : cur_idx + IW'(1);
        if (is_last) bus.FinalAlpha <= rec;
      end else begin
        bus.out_valid    <= 1'b0;
        bus.AlphaMetric  <= '0;
        bus.symbol_index <= '0;
        bus.block_last   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_alpha.sv
// Bench for stream_alpha: directed vector table plus random blocks scored against a real-arithmetic model.
module tb_stream_alpha;
  localparam logic [15:0] NEG_MAX = 16'hFBFF;
  localparam logic [63:0] INIT    = {NEG_MAX, NEG_MAX, NEG_MAX, 16'h0000};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  trellis_if #(.STATES(4), .BITS_PER_SYMBOL(2)) trel ();
  stream_alpha_if #(.BITS(16), .STATES(4), .OUTPUT_SYMBOLS(4), .INDEX_BITS(4)) bus ();

  stream_alpha #(.BITS(16), .PRECISION("HALF"), .STATES(4), .BITS_PER_SYMBOL(2), .SYMBOLS(10)) dut (
    .clk(clk), .rst_n(rst_n), .trellis(trel), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Four-state shift-register trellis
  function automatic int ns(input int s, input int u);
    return (s * 2 + u) % 4;
  endfunction
  function automatic int os(input int s, input int u);
    return u * 2 + (u ^ (s & 1) ^ ((s >> 1) & 1));
  endfunction

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else        repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  ex;
    ex = int'(h[14:10]);
    if (ex == 0) m = real'(h[9:0]) * pow2(-24);
    else         m = real'(1024 + int'(h[9:0])) * pow2(ex - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v, input logic zsign);
    real  m, q, n, f, diff;
    int   e, ri;
    logic s;
    bit   subn;
    s = (v < 0.0);
    m = s ? -v : v;
    if (m == 0.0) return {zsign, 15'd0};
    if (m >= 65520.0) return s ? NEG_MAX : 16'h7C00;
    e = 15;
    while (e > -14 && m < pow2(e)) e--;
    subn = (m < pow2(-14));
    q = subn ? pow2(-24) : pow2(e - 10);
    n = m / q;
    f = $floor(n);
    diff = n - f;
    if (diff > 0.5 || (diff == 0.5 && (int'(f) % 2) == 1)) f = f + 1.0;
    ri = int'(f);
    if (subn) return {s, 15'(ri)};
    if (ri == 2048) begin ri = 1024; e++; end
    if (e > 15) return s ? NEG_MAX : 16'h7C00;
    return {s, 5'(e + 15), 10'(ri - 1024)};
  endfunction

  function automatic logic [63:0] step(input logic [63:0] a_in, input logic [63:0] g_in);
    logic [3:0][15:0] a, g, r;
    logic [15:0]      c;
    bit               found;
    a = a_in;
    g = g_in;
    for (int t = 0; t < 4; t++) begin
      r[t]  = NEG_MAX;
      found = 0;
      for (int s = 0; s < 4; s++)
        for (int u = 0; u < 2; u++)
          if (ns(s, u) == t) begin
            c = r2h(h2r(a[s]) + h2r(g[os(s, u)]), a[s][15] & g[os(s, u)][15]);
            if (!found || h2r(c) > h2r(r[t])) r[t] = c;
            found = 1;
          end
    end
    return r;
  endfunction

  function automatic logic [15:0] rnd_half();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), 10'($urandom_range(0, 1023))};
  endfunction
  function automatic logic [63:0] rnd_vec();
    return {rnd_half(), rnd_half(), rnd_half(), rnd_half()};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [63:0] m_alpha, m_fin;
  bit          m_run, m_prev_last;
  int          m_cnt;

  task automatic m_reset();
    m_alpha = INIT; m_fin = '0; m_run = 0; m_prev_last = 0; m_cnt = 0;
  endtask

  task automatic apply(input logic iv, input logic bs, input logic [63:0] g);
    logic        e_ov, e_last, e_perr, e_fv;
    logic [3:0]  e_idx;
    logic [63:0] e_am;
    e_ov = 0; e_last = 0; e_perr = 0; e_idx = '0; e_am = '0;
    e_fv = m_prev_last;
    if (iv && (bs || m_run)) begin
      e_ov    = 1;
      e_idx   = bs ? 4'd0 : 4'(m_cnt);
      e_am    = bs ? INIT : m_alpha;
      m_alpha = step(e_am, g);
      if (e_idx == 4'd9) begin
        e_last = 1; m_fin = m_alpha; m_run = 0; m_cnt = 0;
      end else begin
        m_run = 1; m_cnt = int'(e_idx) + 1;
      end
    end else if (iv) begin
      e_perr = 1;
    end
    m_prev_last = e_last;
    bus.in_valid = iv; bus.block_start = bs; bus.branch_metric = g;
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, e_ov);
    chk("symbol_index", bus.symbol_index, e_idx);
    chk("block_last", bus.block_last, e_last);
    chk("AlphaMetric", bus.AlphaMetric, e_am);
    chk("protocol_error", bus.protocol_error, e_perr);
    chk("final_valid", bus.final_valid, e_fv);
    chk("FinalAlpha", bus.FinalAlpha, m_fin);
  endtask

  task automatic run_block(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      apply(1'b1, i == 0, rnd_vec());
      repeat ($urandom_range(0, maxgap)) apply(1'b0, 1'b0, rnd_vec());
    end
  endtask

  typedef struct {
    logic        iv;
    logic        bs;
    logic [15:0] g;
    logic        ov;
    logic [3:0]  idx;
    logic [63:0] am;
    logic        perr;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'h3C00, 1'b1, 4'd0, INIT, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h3C00, 1'b1, 4'd1, {NEG_MAX, NEG_MAX, 16'h3C00, 16'h3C00}, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h3C00, 1'b1, 4'd2, {4{16'h4000}}, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h3C00, 1'b0, 4'd0, 64'd0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h3C00, 1'b1, 4'd3, {4{16'h4200}}, 1'b0};

    for (int s = 0; s < 4; s++)
      for (int u = 0; u < 2; u++) begin
        trel.NEXT_STATE[s][u] = 2'(ns(s, u));
        trel.OUTPUT[s][u]     = 2'(os(s, u));
      end
    bus.in_valid = 1'b0; bus.block_start = 1'b0; bus.branch_metric = '0;
    m_reset();

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_AlphaMetric", bus.AlphaMetric, 0);
    chk("rst_symbol_index", bus.symbol_index, 0);
    chk("rst_block_last", bus.block_last, 0);
    chk("rst_final_valid", bus.final_valid, 0);
    chk("rst_FinalAlpha", bus.FinalAlpha, 0);
    chk("rst_protocol_error", bus.protocol_error, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      bus.in_valid = tbl[i].iv; bus.block_start = tbl[i].bs; bus.branch_metric = {4{tbl[i].g}};
      @(posedge clk); #1;
      chk("tbl_out_valid", bus.out_valid, tbl[i].ov);
      chk("tbl_symbol_index", bus.symbol_index, tbl[i].idx);
      chk("tbl_AlphaMetric", bus.AlphaMetric, tbl[i].am);
      chk("tbl_protocol_error", bus.protocol_error, tbl[i].perr);
      chk("tbl_block_last", bus.block_last, 0);
    end
    apply(1'b0, 1'b0, '0);

    repeat (3) run_block(10, 3);
    apply(1'b0, 1'b0, '0);

    // Abort at symbol 4, then complete the restarted block
    run_block(4, 1);
    run_block(10, 2);
    apply(1'b0, 1'b0, '0);

    // Stray symbols while idle
    apply(1'b1, 1'b0, rnd_vec());
    apply(1'b1, 1'b0, rnd_vec());
    apply(1'b0, 1'b0, rnd_vec());

    // Saturation
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, i == 0, {4{NEG_MAX}});
      for (int k = 0; k < 4; k++)
        chk("sat_finite", bus.AlphaMetric[k][14:10] == 5'h1F, 0);
    end
    apply(1'b0, 1'b0, '0);

    // Asynchronous reset mid-block
    run_block(3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_AlphaMetric", bus.AlphaMetric, 0);
    chk("midrst_symbol_index", bus.symbol_index, 0);
    chk("midrst_FinalAlpha", bus.FinalAlpha, 0);
    m_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply(1'b1, 1'b0, rnd_vec());
    apply(1'b0, 1'b0, rnd_vec());

    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2)      apply(1'b0, 1'b0, rnd_vec());
      else if (r < 3) apply(1'b1, 1'b1, rnd_vec());
      else            apply(1'b1, 1'b0, rnd_vec());
    end
    apply(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
